// File: rtl/div_exec_unit.sv
// Multi-cycle radix-2 restoring DIV/DIVU/REM/REMU unit with CDB request/grant handshake.
// Optional macro DIV_EARLY_TERM_EN: divide-by-zero and signed overflow bypass the iteration.
module div_exec_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_issue_valid,
    input  logic [1:0]       i_issue_op,
    input  logic [XLEN-1:0]  i_rs1_data,
    input  logic [XLEN-1:0]  i_rs2_data,
    input  logic [TAG_W-1:0] i_rd_tag,
    input  logic             i_flush,
    output logic             o_busy,
    output logic             o_cdb_req,
    input  logic             i_cdb_grant,
    output logic [TAG_W-1:0] o_cdb_tag,
    output logic [XLEN-1:0]  o_cdb_result
);

    localparam int unsigned CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [TAG_W-1:0] r_tag;
    logic [XLEN-1:0]  r_rs1;
    logic [XLEN-1:0]  r_divisor;
    logic [XLEN-1:0]  r_quo;
    logic [XLEN-1:0]  r_rem;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sel_rem;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_div0;
    logic             r_ovf;
    logic             r_cdb_req;
    logic [XLEN-1:0]  r_result;

    logic             w_signed_in;
    logic             w_neg1;
    logic             w_neg2;
    logic [XLEN-1:0]  w_abs1;
    logic [XLEN-1:0]  w_abs2;
    logic             w_div0_in;
    logic             w_ovf_in;
    logic             w_accept;
    logic [XLEN:0]    w_shift;
    logic [XLEN:0]    w_trial;
    logic             w_ge;
    logic [XLEN-1:0]  w_quo_fix;
    logic [XLEN-1:0]  w_rem_fix;
    logic [XLEN-1:0]  w_fix_result;

    // Operand conditioning at issue: signed ops divide magnitudes.
    always_comb begin
        w_signed_in = ~i_issue_op[0];
        w_neg1      = w_signed_in & i_rs1_data[XLEN-1];
        w_neg2      = w_signed_in & i_rs2_data[XLEN-1];
        w_abs1      = w_neg1 ? XLEN'(-i_rs1_data) : i_rs1_data;
        w_abs2      = w_neg2 ? XLEN'(-i_rs2_data) : i_rs2_data;
        w_div0_in   = (i_rs2_data == '0);
        w_ovf_in    = w_signed_in
                      && (i_rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                      && (i_rs2_data == '1);
        w_accept    = (r_state == S_IDLE) && i_issue_valid && !i_flush;
    end

    // One restoring step: the shifted partial remainder is the XLEN+1 bit accumulator.
    always_comb begin
        w_shift = {r_rem, r_quo[XLEN-1]};
        w_trial = w_shift - {1'b0, r_divisor};
        w_ge    = ~w_trial[XLEN];
    end

    // Sign correction and RISC-V special-case override.
    always_comb begin
        w_quo_fix = r_sign_q ? XLEN'(-r_quo) : r_quo;
        w_rem_fix = r_sign_r ? XLEN'(-r_rem) : r_rem;
        if (r_div0) begin
            w_quo_fix = '1;
            w_rem_fix = r_rs1;
        end else if (r_ovf) begin
            w_quo_fix = r_rs1;
            w_rem_fix = '0;
        end
        w_fix_result = r_sel_rem ? w_rem_fix : w_quo_fix;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_issue_valid) begin
`ifdef DIV_EARLY_TERM_EN
                    w_next_state = (w_div0_in || w_ovf_in) ? S_FIX : S_ITER;
`else
                    w_next_state = S_ITER;
`endif
                end
            end
            S_ITER: begin
                if (r_cnt == CNT_W'(XLEN - 1)) begin
                    w_next_state = S_FIX;
                end
            end
            S_FIX: begin
                w_next_state = S_DONE;
            end
            S_DONE: begin
                if (i_cdb_grant) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        if (i_flush) begin
            w_next_state = S_IDLE;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tag     <= '0;
            r_rs1     <= '0;
            r_divisor <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_sel_rem <= 1'b0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
            r_div0    <= 1'b0;
            r_ovf     <= 1'b0;
            r_cdb_req <= 1'b0;
            r_result  <= '0;
        end else begin
            r_cdb_req <= (w_next_state == S_DONE);
            if (w_accept) begin
                r_tag     <= i_rd_tag;
                r_rs1     <= i_rs1_data;
                r_divisor <= w_abs2;
                r_quo     <= w_abs1;
                r_rem     <= '0;
                r_cnt     <= '0;
                r_sel_rem <= i_issue_op[1];
                r_sign_q  <= w_neg1 ^ w_neg2;
                r_sign_r  <= w_neg1;
                r_div0    <= w_div0_in;
                r_ovf     <= w_ovf_in;
            end
            if (r_state == S_ITER) begin
                r_rem <= w_ge ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
                r_quo <= {r_quo[XLEN-2:0], w_ge};
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_state == S_FIX) begin
                r_result <= w_fix_result;
            end
        end
    end

    assign o_busy       = (r_state != S_IDLE);
    assign o_cdb_req    = r_cdb_req;
    assign o_cdb_tag    = r_tag;
    assign o_cdb_result = r_result;

    // Issue while occupied is a protocol violation unless the same cycle flushes.
    a_no_issue_when_busy: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_issue_valid && o_busy && !i_flush));

endmodule

// File: tb/tb_div_exec_unit.sv
// Directed self-checking bench for div_exec_unit; expected latency follows DIV_EARLY_TERM_EN.
module tb_div_exec_unit;

`ifdef DIV_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [1:0]  issue_op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [5:0]  rd_tag;
    logic        flush;
    logic        busy;
    logic        cdb_req;
    logic        cdb_grant;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_result;

    int checks = 0;
    int errors = 0;

    div_exec_unit #(.XLEN(32), .TAG_W(6)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_issue_valid(issue_valid),
        .i_issue_op   (issue_op),
        .i_rs1_data   (rs1),
        .i_rs2_data   (rs2),
        .i_rd_tag     (rd_tag),
        .i_flush      (flush),
        .o_busy       (busy),
        .o_cdb_req    (cdb_req),
        .i_cdb_grant  (cdb_grant),
        .o_cdb_tag    (cdb_tag),
        .o_cdb_result (cdb_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [5:0] tag, input logic [31:0] exp,
                          input bit special, input int hold);
        int lat;
        int exp_lat;
        exp_lat = (EARLY && special) ? 1 : 33;
        issue_valid = 1'b1;
        issue_op    = op;
        rs1         = a;
        rs2         = b;
        rd_tag      = tag;
        tick();
        issue_valid = 1'b0;
        lat = 0;
        while (!cdb_req && lat < 100) begin
            tick();
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_result"}, cdb_result, exp);
        check({name, "_tag"}, 32'(cdb_tag), 32'(tag));
        for (int i = 0; i < hold; i++) begin
            tick();
            check({name, "_hold_req"}, 32'(cdb_req), 32'd1);
            check({name, "_hold_busy"}, 32'(busy), 32'd1);
            check({name, "_hold_result"}, cdb_result, exp);
            check({name, "_hold_tag"}, 32'(cdb_tag), 32'(tag));
        end
        cdb_grant = 1'b1;
        tick();
        cdb_grant = 1'b0;
        check({name, "_post_busy"}, 32'(busy), 32'd0);
        check({name, "_post_req"}, 32'(cdb_req), 32'd0);
    endtask

    initial begin
        bit seen;
        rst         = 1'b1;
        issue_valid = 1'b0;
        issue_op    = 2'd0;
        rs1         = '0;
        rs2         = '0;
        rd_tag      = '0;
        flush       = 1'b0;
        cdb_grant   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_req", 32'(cdb_req), 32'd0);
        check("reset_tag", 32'(cdb_tag), 32'd0);
        check("reset_result", cdb_result, 32'd0);

        // Each op issues the cycle after the previous grant (back-to-back spacing).
        run_op("divu_100_7", 2'd1, 32'd100, 32'd7, 6'd5, 32'd14, 1'b0, 0);
        run_op("remu_100_7", 2'd3, 32'd100, 32'd7, 6'd6, 32'd2, 1'b0, 0);
        run_op("div_m7_2", 2'd0, 32'hFFFF_FFF9, 32'd2, 6'd7, 32'hFFFF_FFFD, 1'b0, 0);
        run_op("rem_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 6'd8, 32'hFFFF_FFFF, 1'b0, 0);
        run_op("divu_big", 2'd1, 32'hFFFF_FFFF, 32'h10, 6'd10, 32'h0FFF_FFFF, 1'b0, 0);
        run_op("div_by0", 2'd0, 32'd1234, 32'd0, 6'd20, 32'hFFFF_FFFF, 1'b1, 0);
        run_op("remu_by0", 2'd3, 32'd1234, 32'd0, 6'd21, 32'd1234, 1'b1, 0);
        run_op("div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 6'd22, 32'h8000_0000, 1'b1, 0);
        run_op("rem_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 6'd23, 32'd0, 1'b1, 0);
        run_op("grant_wait", 2'd1, 32'd100, 32'd7, 6'd9, 32'd14, 1'b0, 10);

        // Flush at iteration count 10 together with a new issue.
        issue_valid = 1'b1;
        issue_op    = 2'd1;
        rs1         = 32'd100;
        rs2         = 32'd7;
        rd_tag      = 6'd3;
        tick();
        issue_valid = 1'b0;
        repeat (10) tick();
        check("flush_pre_busy", 32'(busy), 32'd1);
        flush       = 1'b1;
        issue_valid = 1'b1;
        rs1         = 32'd50;
        rs2         = 32'd5;
        rd_tag      = 6'd4;
        tick();
        flush       = 1'b0;
        issue_valid = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_req", 32'(cdb_req), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (cdb_req || busy) seen = 1'b1;
        end
        check("flush_quiet", 32'(seen), 32'd0);

        // Asynchronous reset in the middle of iteration.
        issue_valid = 1'b1;
        issue_op    = 2'd1;
        rs1         = 32'd100;
        rs2         = 32'd7;
        rd_tag      = 6'd11;
        tick();
        issue_valid = 1'b0;
        repeat (5) tick();
        check("pre_rst_tag", 32'(cdb_tag), 32'd11);
        #2;
        rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req", 32'(cdb_req), 32'd0);
        check("rst_tag", 32'(cdb_tag), 32'd0);
        check("rst_result", cdb_result, 32'd0);
        tick();
        rst = 1'b0;
        run_op("after_rst", 2'd1, 32'd100, 32'd7, 6'd12, 32'd14, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
